// File: rtl/lc3_decode_pkg.sv
// Shared LC-3 decode definitions: opcodes, widths, FSM states and the
// operand bundle handed to execute.
package lc3_pkg;

  localparam int XLEN = 16;
  localparam int NREG = 8;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RES  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0]      opcode;
    logic [3:0]      ir11;
    logic [2:0]      dr;
    logic            writes_dr;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] offset;
    logic [XLEN-1:0] pc;
  } bundle_t;

endpackage

// File: rtl/lc3_decode_if.sv
// Decode-stage bus: fetch handshake, register file read port, writeback
// notification and the operand bundle towards execute.
interface lc3_decode_if;
  import lc3_pkg::*;

  logic            IN_VALID;
  logic            IN_READY;
  logic [XLEN-1:0] IN_INSTR;
  logic [XLEN-1:0] IN_PC;
  logic [2:0]      RS1;
  logic [2:0]      RS2;
  logic [XLEN-1:0] RS1_DATA;
  logic [XLEN-1:0] RS2_DATA;
  logic            WB_VALID;
  logic [2:0]      WB_DR;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [3:0]      OUT_OPCODE;
  logic [3:0]      OUT_IR11;
  logic [2:0]      OUT_DR;
  logic            OUT_WRITES_DR;
  logic [XLEN-1:0] OUT_SRC1;
  logic [XLEN-1:0] OUT_SRC2;
  logic [XLEN-1:0] OUT_OFFSET;
  logic [XLEN-1:0] OUT_PC;

  modport slave (
    input  IN_VALID, IN_INSTR, IN_PC, RS1_DATA, RS2_DATA, WB_VALID, WB_DR, OUT_READY,
    output IN_READY, RS1, RS2, OUT_VALID, OUT_OPCODE, OUT_IR11, OUT_DR,
           OUT_WRITES_DR, OUT_SRC1, OUT_SRC2, OUT_OFFSET, OUT_PC
  );

  modport master (
    output IN_VALID, IN_INSTR, IN_PC, RS1_DATA, RS2_DATA, WB_VALID, WB_DR, OUT_READY,
    input  IN_READY, RS1, RS2, OUT_VALID, OUT_OPCODE, OUT_IR11, OUT_DR,
           OUT_WRITES_DR, OUT_SRC1, OUT_SRC2, OUT_OFFSET, OUT_PC
  );

endinterface

// File: rtl/lc3_decode_scoreboard.sv
// Register busy scoreboard: tracks in-flight writes and flags read/write
// hazards against the registered busy bits only (no writeback bypass).
module lc3_scoreboard
  import lc3_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       set_en,
  input  logic [2:0] set_idx,
  input  logic       clr_en,
  input  logic [2:0] clr_idx,
  input  logic [2:0] rs1,
  input  logic [2:0] rs2,
  input  logic [2:0] dr,
  input  logic       use1,
  input  logic       use2,
  input  logic       wr,
  output logic       hazard
);

  localparam logic [NREG-1:0] BIT0 = {{(NREG-1){1'b0}}, 1'b1};

  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] set_mask_s;
  logic [NREG-1:0] clr_mask_s;

  assign set_mask_s = set_en ? (BIT0 << set_idx) : {NREG{1'b0}};
  assign clr_mask_s = clr_en ? (BIT0 << clr_idx) : {NREG{1'b0}};

  // Clear is applied before set so a same-bit collision leaves the bit busy.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      busy_r <= {NREG{1'b0}};
    end else begin
      busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
    end
  end

  assign hazard = (use1 & busy_r[rs1]) | (use2 & busy_r[rs2]) | (wr & busy_r[dr]);

endmodule

// File: rtl/lc3_decode.sv
// LC-3 decode / operand-fetch stage: latches one instruction, reads the
// register file once it is hazard-free and presents the operand bundle.
module lc3_decode
  import lc3_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  lc3_decode_if.slave  bus
);

  state_e          state_r;
  state_e          state_nxt_s;
  logic [XLEN-1:0] ir_r;
  logic [XLEN-1:0] pc_r;
  bundle_t         out_r;
  logic            out_valid_r;

  opcode_e         op_s;
  logic [2:0]      rs1_s;
  logic [2:0]      rs2_s;
  logic [2:0]      dr_s;
  logic            use1_s;
  logic            use2_s;
  logic            writes_dr_s;
  logic            imm_s;
  logic [XLEN-1:0] offset_s;
  logic [XLEN-1:0] src2_s;
  logic            hazard_s;
  logic            in_ready_s;
  logic            xfer_s;

  // Field decode of the latched instruction.
  always_comb begin
    op_s        = opcode_e'(ir_r[15:12]);
    rs1_s       = ir_r[8:6];
    rs2_s       = ir_r[2:0];
    dr_s        = ir_r[11:9];
    use1_s      = 1'b0;
    use2_s      = 1'b0;
    writes_dr_s = 1'b0;
    imm_s       = 1'b0;
    offset_s    = 16'h0000;
    case (op_s)
      OP_ADD, OP_AND: begin
        use1_s      = 1'b1;
        use2_s      = ~ir_r[5];
        imm_s       = ir_r[5];
        writes_dr_s = 1'b1;
      end
      OP_NOT: begin
        use1_s      = 1'b1;
        writes_dr_s = 1'b1;
      end
      OP_LD, OP_LDI, OP_LEA: begin
        writes_dr_s = 1'b1;
        offset_s    = {{7{ir_r[8]}}, ir_r[8:0]};
      end
      OP_LDR: begin
        use1_s      = 1'b1;
        writes_dr_s = 1'b1;
        offset_s    = {{10{ir_r[5]}}, ir_r[5:0]};
      end
      OP_STR: begin
        use1_s   = 1'b1;
        use2_s   = 1'b1;
        rs2_s    = ir_r[11:9];
        offset_s = {{10{ir_r[5]}}, ir_r[5:0]};
      end
      OP_ST, OP_STI: begin
        use2_s   = 1'b1;
        rs2_s    = ir_r[11:9];
        offset_s = {{7{ir_r[8]}}, ir_r[8:0]};
      end
      OP_BR: begin
        offset_s = {{7{ir_r[8]}}, ir_r[8:0]};
      end
      OP_JMP: begin
        use1_s = 1'b1;
      end
      OP_JSR: begin
        // IR[11] selects PC-relative JSR versus register-based JSRR.
        use1_s      = ~ir_r[11];
        dr_s        = 3'd7;
        writes_dr_s = 1'b1;
        offset_s    = ir_r[11] ? {{5{ir_r[10]}}, ir_r[10:0]} : 16'h0000;
      end
      OP_TRAP: begin
        dr_s        = 3'd7;
        writes_dr_s = 1'b1;
        offset_s    = {8'h00, ir_r[7:0]};
      end
      OP_RTI, OP_RES: begin
        writes_dr_s = 1'b0;
      end
      default: begin
        writes_dr_s = 1'b0;
      end
    endcase
    src2_s = imm_s ? {{11{ir_r[4]}}, ir_r[4:0]} : bus.RS2_DATA;
  end

  assign in_ready_s = (state_r == ST_EMPTY) | ((state_r == ST_HOLD) & bus.OUT_READY);
  assign xfer_s     = bus.IN_VALID & in_ready_s;

  // Next-state logic of the decode FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY:   state_nxt_s = xfer_s ? ST_ISSUE : ST_EMPTY;
      ST_ISSUE:   state_nxt_s = hazard_s ? ST_ISSUE : ST_CAPTURE;
      ST_CAPTURE: state_nxt_s = ST_HOLD;
      ST_HOLD: begin
        if (bus.OUT_READY) begin
          state_nxt_s = xfer_s ? ST_ISSUE : ST_EMPTY;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default:    state_nxt_s = ST_EMPTY;
    endcase
  end

  // State, instruction latch and output bundle registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= ST_EMPTY;
      ir_r        <= 16'h0000;
      pc_r        <= 16'h0000;
      out_r       <= '0;
      out_valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (xfer_s) begin
        ir_r <= bus.IN_INSTR;
        pc_r <= bus.IN_PC;
      end
      if (state_r == ST_CAPTURE) begin
        out_r.opcode    <= ir_r[15:12];
        out_r.ir11      <= {ir_r[11:9], ir_r[11]};
        out_r.dr        <= dr_s;
        out_r.writes_dr <= writes_dr_s;
        out_r.src1      <= bus.RS1_DATA;
        out_r.src2      <= src2_s;
        out_r.offset    <= offset_s;
        out_r.pc        <= pc_r;
        out_valid_r     <= 1'b1;
      end else if ((state_r == ST_HOLD) && bus.OUT_READY) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  lc3_scoreboard u_sb (
    .CLK     (CLK),
    .RESET   (RESET),
    .set_en  ((state_r == ST_CAPTURE) & writes_dr_s),
    .set_idx (dr_s),
    .clr_en  (bus.WB_VALID),
    .clr_idx (bus.WB_DR),
    .rs1     (rs1_s),
    .rs2     (rs2_s),
    .dr      (dr_s),
    .use1    (use1_s),
    .use2    (use2_s),
    .wr      (writes_dr_s),
    .hazard  (hazard_s)
  );

  assign bus.IN_READY      = in_ready_s;
  assign bus.RS1           = rs1_s;
  assign bus.RS2           = rs2_s;
  assign bus.OUT_VALID     = out_valid_r;
  assign bus.OUT_OPCODE    = out_r.opcode;
  assign bus.OUT_IR11      = out_r.ir11;
  assign bus.OUT_DR        = out_r.dr;
  assign bus.OUT_WRITES_DR = out_r.writes_dr;
  assign bus.OUT_SRC1      = out_r.src1;
  assign bus.OUT_SRC2      = out_r.src2;
  assign bus.OUT_OFFSET    = out_r.offset;
  assign bus.OUT_PC        = out_r.pc;

endmodule
